// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - 4-master round-robin Wishbone arbiter; optional watchdog under WB_ARB_TIMEOUT_EN
module wb_rr_arbiter #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [3:0]   m_wbd_cyc_i,
   input  logic [3:0]   m_wbd_stb_i,
   input  logic [3:0]   m_wbd_we_i,
   input  logic [3:0]   m_wbd_bry_i,
   input  logic [127:0] m_wbd_adr_i,
   input  logic [127:0] m_wbd_dat_i,
   input  logic [15:0]  m_wbd_sel_i,
   input  logic [39:0]  m_wbd_bl_i,
   input  logic [15:0]  m_wbd_tid_i,
   output logic [31:0]  m_wbd_dat_o,
   output logic [3:0]   m_wbd_ack_o,
   output logic [3:0]   m_wbd_lack_o,
   output logic [3:0]   m_wbd_err_o,
   output logic         s_wbd_cyc_o,
   output logic         s_wbd_stb_o,
   output logic         s_wbd_we_o,
   output logic         s_wbd_bry_o,
   output logic [31:0]  s_wbd_adr_o,
   output logic [31:0]  s_wbd_dat_o,
   output logic [3:0]   s_wbd_sel_o,
   output logic [9:0]   s_wbd_bl_o,
   output logic [3:0]   s_wbd_tid_o,
   input  logic [31:0]  s_wbd_dat_i,
   input  logic         s_wbd_ack_i,
   input  logic         s_wbd_lack_i,
   input  logic         s_wbd_err_i
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [1:0] gnt, gnt_nxt;
   logic [1:0] last_gnt, last_gnt_nxt;
   logic [3:0] req;
   logic [1:0] rr_idx;
   logic [1:0] rr_win;
   logic       rr_found;
   logic       timeout;
   logic       release_c;

   assign req = m_wbd_cyc_i & m_wbd_stb_i;

   // Search starts one past the last winner so every requester is reached within 4 grants.
   always_comb begin
      rr_found = 1'b0;
      rr_win   = 2'd0;
      rr_idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         rr_idx = last_gnt + 2'(i);
         if (!rr_found && req[rr_idx]) begin
            rr_found = 1'b1;
            rr_win   = rr_idx;
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [9:0] wd_cnt;

   assign timeout = (state == BUSY) && (wd_cnt == 10'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state != BUSY || s_wbd_ack_i || timeout) begin
         wd_cnt <= '0;
      end else if (m_wbd_cyc_i[gnt] && m_wbd_stb_i[gnt]) begin
         wd_cnt <= wd_cnt + 10'd1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign release_c = !m_wbd_cyc_i[gnt] || (s_wbd_ack_i && s_wbd_lack_i) || s_wbd_err_i || timeout;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= 2'd0;
         last_gnt <= 2'd3;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         last_gnt <= last_gnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      last_gnt_nxt = last_gnt;
      s_wbd_cyc_o  = 1'b0;
      s_wbd_stb_o  = 1'b0;
      s_wbd_we_o   = 1'b0;
      s_wbd_bry_o  = 1'b0;
      s_wbd_adr_o  = '0;
      s_wbd_dat_o  = '0;
      s_wbd_sel_o  = '0;
      s_wbd_bl_o   = '0;
      s_wbd_tid_o  = '0;
      m_wbd_dat_o  = '0;
      m_wbd_ack_o  = '0;
      m_wbd_lack_o = '0;
      m_wbd_err_o  = '0;
      case (state)
         IDLE: begin
            if (rr_found) begin
               state_nxt = BUSY;
               gnt_nxt   = rr_win;
            end
         end
         BUSY: begin
            // A watchdog expiry pulls cyc/stb down in the same cycle it reports err.
            s_wbd_cyc_o       = m_wbd_cyc_i[gnt] & ~timeout;
            s_wbd_stb_o       = m_wbd_stb_i[gnt] & ~timeout;
            s_wbd_we_o        = m_wbd_we_i[gnt];
            s_wbd_bry_o       = m_wbd_bry_i[gnt];
            s_wbd_adr_o       = m_wbd_adr_i[gnt*32 +: 32];
            s_wbd_dat_o       = m_wbd_dat_i[gnt*32 +: 32];
            s_wbd_sel_o       = m_wbd_sel_i[gnt*4 +: 4];
            s_wbd_bl_o        = m_wbd_bl_i[gnt*10 +: 10];
            s_wbd_tid_o       = m_wbd_tid_i[gnt*4 +: 4];
            m_wbd_dat_o       = s_wbd_dat_i;
            m_wbd_ack_o[gnt]  = s_wbd_ack_i;
            m_wbd_lack_o[gnt] = s_wbd_lack_i;
            m_wbd_err_o[gnt]  = s_wbd_err_i | timeout;
            if (release_c) begin
               state_nxt    = IDLE;
               last_gnt_nxt = gnt;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

   localparam int TO = 16;

   logic         clk_i = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   m_cyc, m_stb, m_we, m_bry;
   logic [127:0] m_adr, m_dat;
   logic [15:0]  m_sel, m_tid;
   logic [39:0]  m_bl;
   logic [31:0]  m_dat_o;
   logic [3:0]   m_ack_o, m_lack_o, m_err_o;
   logic         s_cyc_o, s_stb_o, s_we_o, s_bry_o;
   logic [31:0]  s_adr_o, s_dat_o;
   logic [3:0]   s_sel_o, s_tid_o;
   logic [9:0]   s_bl_o;
   logic [31:0]  s_dat_i;
   logic         s_ack_i, s_lack_i, s_err_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   wb_rr_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .clk_i(clk_i), .rst_n(rst_n),
      .m_wbd_cyc_i(m_cyc), .m_wbd_stb_i(m_stb), .m_wbd_we_i(m_we), .m_wbd_bry_i(m_bry),
      .m_wbd_adr_i(m_adr), .m_wbd_dat_i(m_dat), .m_wbd_sel_i(m_sel),
      .m_wbd_bl_i(m_bl), .m_wbd_tid_i(m_tid),
      .m_wbd_dat_o(m_dat_o), .m_wbd_ack_o(m_ack_o), .m_wbd_lack_o(m_lack_o), .m_wbd_err_o(m_err_o),
      .s_wbd_cyc_o(s_cyc_o), .s_wbd_stb_o(s_stb_o), .s_wbd_we_o(s_we_o), .s_wbd_bry_o(s_bry_o),
      .s_wbd_adr_o(s_adr_o), .s_wbd_dat_o(s_dat_o), .s_wbd_sel_o(s_sel_o),
      .s_wbd_bl_o(s_bl_o), .s_wbd_tid_o(s_tid_o),
      .s_wbd_dat_i(s_dat_i), .s_wbd_ack_i(s_ack_i), .s_wbd_lack_i(s_lack_i), .s_wbd_err_i(s_err_i)
   );

   function automatic logic [129:0] dut_vec();
      return {s_cyc_o, s_stb_o, s_we_o, s_bry_o, s_adr_o, s_dat_o, s_sel_o, s_bl_o, s_tid_o,
              m_dat_o, m_ack_o, m_lack_o, m_err_o};
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      m_cyc = '0; m_stb = '0; m_we = '0; m_bry = '0;
      m_adr = '0; m_dat = '0; m_sel = '0; m_bl = '0; m_tid = '0;
      s_dat_i = '0; s_ack_i = 1'b0; s_lack_i = 1'b0; s_err_i = 1'b0;
   endtask

   task automatic set_master(input int k, input logic [31:0] adr, input logic we,
                             input logic [9:0] bl, input logic [3:0] tid);
      m_cyc[k] = 1'b1;
      m_stb[k] = 1'b1;
      m_we[k]  = we;
      m_bry[k] = 1'b1;
      m_adr[32*k +: 32] = adr;
      m_dat[32*k +: 32] = ~adr;
      m_sel[4*k +: 4]   = 4'hf;
      m_bl[10*k +: 10]  = bl;
      m_tid[4*k +: 4]   = tid;
   endtask

   task automatic drop_master(input int k);
      m_cyc[k] = 1'b0;
      m_stb[k] = 1'b0;
   endtask

   task automatic do_reset();
      next_cycle();
      rst_n = 1'b0;
      clear_inputs();
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      set_master(1, 32'h1234_5678, 1'b1, 10'd3, 4'h7);
      s_ack_i = 1'b1; s_err_i = 1'b1; s_lack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
      next_cycle();
      settle();
      checks++;
      if (dut_vec() !== 130'd0)
         $display("FAIL reset_outputs actual=%h expected=0", dut_vec());
      clear_inputs();
   endtask

   task automatic test_single_read();
      do_reset();
      set_master(2, 32'h1000_0040, 1'b0, 10'd1, 4'h5);
      settle();
      checks++;
      if (s_stb_o !== 1'b0) begin
         failures++; $display("FAIL rd_req_cycle_stb actual=%b expected=0", s_stb_o);
      end
      next_cycle(); settle();
      checks++;
      if ({s_stb_o, s_cyc_o, s_adr_o, s_tid_o} !== {2'b11, 32'h1000_0040, 4'h5}) begin
         failures++;
         $display("FAIL rd_grant actual=%h expected=%h", {s_stb_o, s_cyc_o, s_adr_o, s_tid_o},
                  {2'b11, 32'h1000_0040, 4'h5});
      end
      next_cycle(); next_cycle(); next_cycle();
      s_ack_i = 1'b1; s_lack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      settle();
      checks++;
      if ({m_ack_o, m_lack_o, m_err_o, m_dat_o} !== {4'b0100, 4'b0100, 4'b0000, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL rd_ack actual=%h expected=%h", {m_ack_o, m_lack_o, m_err_o, m_dat_o},
                  {4'b0100, 4'b0100, 4'b0000, 32'hDEAD_BEEF});
      end
      next_cycle();
      s_ack_i = 1'b0; s_lack_i = 1'b0; s_dat_i = '0;
      settle();
      checks++;
      if ({s_cyc_o, s_stb_o, m_ack_o} !== 6'd0) begin
         failures++; $display("FAIL rd_idle_after_lack actual=%h expected=0", {s_cyc_o, s_stb_o, m_ack_o});
      end
      drop_master(2);
      next_cycle();
   endtask

   task automatic test_fairness();
      logic       exp_busy;
      int         exp_m;
      logic [36:0] act, exp;
      do_reset();
      for (int k = 0; k < 4; k++) set_master(k, 32'(k), 1'b0, 10'd1, 4'(k));
      s_ack_i = 1'b1; s_lack_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         settle();
         exp_busy = (i % 2) == 1;
         exp_m    = ((i - 1) / 2) % 4;
         exp = exp_busy ? {1'b1, 32'(exp_m), 4'b0001 << exp_m} : 37'd0;
         act = {s_stb_o, s_adr_o, m_ack_o};
         checks++;
         if (act !== exp) begin
            failures++; $display("FAIL fair_cycle%0d actual=%h expected=%h", i, act, exp);
         end
         next_cycle();
      end
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_burst();
      int acks;
      logic [49:0] act, exp;
      do_reset();
      set_master(1, 32'hA000_0100, 1'b1, 10'd4, 4'h1);
      set_master(3, 32'hB000_0300, 1'b0, 10'd1, 4'h3);
      settle();
      next_cycle();
      acks = 0;
      for (int b = 0; b < 4; b++) begin
         s_ack_i = 1'b1; s_lack_i = (b == 3);
         settle();
         act = {m_ack_o, m_lack_o, s_adr_o, s_bl_o};
         exp = {4'b0010, (b == 3) ? 4'b0010 : 4'b0000, 32'hA000_0100, 10'd4};
         checks++;
         if (act !== exp) begin
            failures++; $display("FAIL burst_beat%0d actual=%h expected=%h", b, act, exp);
         end
         if (m_ack_o[1]) acks++;
         next_cycle();
      end
      s_ack_i = 1'b0; s_lack_i = 1'b0;
      drop_master(1);
      settle();
      checks++;
      if (s_stb_o !== 1'b0) begin
         failures++; $display("FAIL burst_dead_cycle actual=%b expected=0", s_stb_o);
      end
      next_cycle(); settle();
      checks++;
      if ({s_stb_o, s_adr_o, s_tid_o} !== {1'b1, 32'hB000_0300, 4'h3}) begin
         failures++;
         $display("FAIL burst_next_grant actual=%h expected=%h", {s_stb_o, s_adr_o, s_tid_o},
                  {1'b1, 32'hB000_0300, 4'h3});
      end
      checks++;
      if (acks != 4) begin
         failures++; $display("FAIL burst_ack_count actual=%0d expected=4", acks);
      end
      clear_inputs();
      next_cycle(); next_cycle();
   endtask

   task automatic test_cyc_drop();
      do_reset();
      set_master(0, 32'h0000_00C0, 1'b0, 10'd8, 4'h0);
      set_master(2, 32'h0000_02C0, 1'b0, 10'd1, 4'h2);
      settle();
      next_cycle();
      s_ack_i = 1'b1;
      for (int b = 0; b < 2; b++) begin
         settle();
         checks++;
         if (m_ack_o !== 4'b0001) begin
            failures++; $display("FAIL drop_beat%0d actual=%b expected=0001", b, m_ack_o);
         end
         next_cycle();
      end
      s_ack_i = 1'b0;
      drop_master(0);
      settle();
      checks++;
      if ({s_cyc_o, s_stb_o} !== 2'b00) begin
         failures++; $display("FAIL drop_same_cycle actual=%b expected=00", {s_cyc_o, s_stb_o});
      end
      next_cycle();
      s_ack_i = 1'b1;
      settle();
      checks++;
      if ({s_stb_o, m_ack_o} !== 5'd0) begin
         failures++; $display("FAIL drop_late_ack actual=%b expected=0", {s_stb_o, m_ack_o});
      end
      next_cycle();
      s_ack_i = 1'b0;
      settle();
      checks++;
      if ({s_stb_o, s_adr_o} !== {1'b1, 32'h0000_02C0}) begin
         failures++;
         $display("FAIL drop_next_grant actual=%h expected=%h", {s_stb_o, s_adr_o}, {1'b1, 32'h0000_02C0});
      end
      clear_inputs();
      next_cycle(); next_cycle();
   endtask

   task automatic test_stall();
      logic bad;
      do_reset();
      set_master(1, 32'h0000_1111, 1'b1, 10'd1, 4'h1);
      settle();
      next_cycle();
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         settle();
         checks++;
         if ({m_err_o, s_stb_o, s_cyc_o} !== ((i == TO - 1) ? 6'b0010_00 : 6'b0000_11)) begin
            failures++;
            $display("FAIL stall_cycle%0d actual=%b expected=%b", i, {m_err_o, s_stb_o, s_cyc_o},
                     (i == TO - 1) ? 6'b0010_00 : 6'b0000_11);
         end
         next_cycle();
      end
      settle();
      checks++;
      if ({m_err_o, s_stb_o} !== 5'd0) begin
         failures++; $display("FAIL stall_released actual=%b expected=0", {m_err_o, s_stb_o});
      end
`else
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         settle();
         if (m_err_o !== 4'd0 || s_stb_o !== 1'b1) bad = 1'b1;
         next_cycle();
      end
      settle();
      checks++;
      if (bad !== 1'b0) begin
         failures++; $display("FAIL stall_err_or_gap actual=%b expected=0", bad);
      end
      checks++;
      if ({s_stb_o, s_adr_o} !== {1'b1, 32'h0000_1111}) begin
         failures++;
         $display("FAIL stall_grant_held actual=%h expected=%h", {s_stb_o, s_adr_o}, {1'b1, 32'h0000_1111});
      end
`endif
      clear_inputs();
      next_cycle(); next_cycle();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      set_master(2, 32'h0000_2222, 1'b0, 10'd4, 4'h2);
      settle();
      next_cycle();
      s_ack_i = 1'b1;
      settle();
      checks++;
      if (m_ack_o !== 4'b0100) begin
         failures++; $display("FAIL rstmid_beat actual=%b expected=0100", m_ack_o);
      end
      next_cycle();
      set_master(0, 32'h0000_0A00, 1'b0, 10'd1, 4'h0);
      s_err_i = 1'b1; s_lack_i = 1'b1; s_dat_i = 32'h0000_FFFF;
      rst_n = 1'b0;
      settle();
      checks++;
      if (dut_vec() !== 130'd0) begin
         failures++; $display("FAIL rstmid_immediate actual=%h expected=0", dut_vec());
      end
      next_cycle(); settle();
      checks++;
      if (dut_vec() !== 130'd0) begin
         failures++; $display("FAIL rstmid_held actual=%h expected=0", dut_vec());
      end
      s_ack_i = 1'b0; s_err_i = 1'b0; s_lack_i = 1'b0; s_dat_i = '0;
      rst_n = 1'b1;
      settle();
      next_cycle(); settle();
      checks++;
      if ({s_stb_o, s_adr_o, m_err_o} !== {1'b1, 32'h0000_0A00, 4'd0}) begin
         failures++;
         $display("FAIL rstmid_first_grant actual=%h expected=%h", {s_stb_o, s_adr_o, m_err_o},
                  {1'b1, 32'h0000_0A00, 4'd0});
      end
      clear_inputs();
      next_cycle(); next_cycle();
   endtask

   task automatic test_random();
      logic         busy;
      int           g, last, wd, w;
      logic         fire, found;
      logic [3:0]   oh, reqv;
      logic [129:0] exp;
      do_reset();
      busy = 1'b0; g = 0; last = 3; wd = 0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 4; k++) begin
            m_cyc[k] = $urandom_range(0, 3) != 0;
            m_stb[k] = m_cyc[k] && ($urandom_range(0, 3) != 0);
            m_we[k]  = 1'($urandom);
            m_bry[k] = 1'($urandom);
            m_adr[32*k +: 32] = $urandom;
            m_dat[32*k +: 32] = $urandom;
            m_sel[4*k +: 4]   = 4'($urandom);
            m_bl[10*k +: 10]  = 10'($urandom);
            m_tid[4*k +: 4]   = 4'($urandom);
         end
         s_ack_i  = 1'($urandom);
         s_lack_i = $urandom_range(0, 2) == 0;
         s_err_i  = $urandom_range(0, 15) == 0;
         s_dat_i  = $urandom;
         settle();
         fire = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
         fire = busy && (wd == TO - 1);
`endif
         exp = '0;
         if (busy) begin
            oh  = 4'b0001 << g;
            exp = {m_cyc[g] & ~fire, m_stb[g] & ~fire, m_we[g], m_bry[g],
                   m_adr[32*g +: 32], m_dat[32*g +: 32], m_sel[4*g +: 4], m_bl[10*g +: 10],
                   m_tid[4*g +: 4], s_dat_i,
                   s_ack_i ? oh : 4'd0, s_lack_i ? oh : 4'd0, (s_err_i || fire) ? oh : 4'd0};
         end
         checks++;
         if (dut_vec() !== exp) begin
            failures++; $display("FAIL random_cycle%0d actual=%h expected=%h", c, dut_vec(), exp);
         end
         if (!busy) begin
            reqv  = m_cyc & m_stb;
            found = 1'b0;
            for (int i = 1; i <= 4; i++) begin
               w = (last + i) % 4;
               if (!found && reqv[w]) begin
                  found = 1'b1; g = w;
               end
            end
            busy = found;
            wd   = 0;
         end else if (!m_cyc[g] || (s_ack_i && s_lack_i) || s_err_i || fire) begin
            busy = 1'b0; last = g; wd = 0;
         end else if (s_ack_i) begin
            wd = 0;
         end else if (m_stb[g]) begin
            wd = wd + 1;
         end
         next_cycle();
      end
      clear_inputs();
      next_cycle();
   endtask

   initial begin
      #400000;
      $display("FAIL global_time_limit actual=expired expected=finish");
      $fatal(1, "time limit");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_fairness();
      test_burst();
      test_cyc_drop();
      test_stall();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
